// File: rtl/data_mem_unit.sv
// Data-memory stage: word-organised RAM behind a three-state req/done handshake (IDLE/ACCESS/RESP).
// Optional macro MISALIGN_TRAP_EN: flag misaligned H/W accesses instead of truncating the address.
module data_mem_unit #(
    parameter int DEPTH_WORDS = 256,
    localparam int IDX_W = $clog2(DEPTH_WORDS)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        done,
    output logic        busy,
    output logic        misaligned
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              we_q, we_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [IDX_W+1:0]  addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;

    logic [31:0]       mem_q [DEPTH_WORDS];

    logic [IDX_W-1:0]  widx_s;
    logic [1:0]        lane_s;
    logic              legal_s;
    logic              mis_s;
    logic              wr_en_s;
    logic [3:0]        be_s;
    logic [31:0]       store_lanes_s;
    logic [31:0]       load_data_s;
    logic              unused_addr_s;

    function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] a,
                                             input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(w >> {a, 3'b000});
        h = a[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b010:  return w;
            3'b100:  return {24'd0, b};
            3'b101:  return {16'd0, h};
            default: return 32'd0;
        endcase
    endfunction

    // Halfword/word lanes ignore the low address bits, which truncates to alignment.
    function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] a);
        case (f3[1:0])
            2'b00:   return 4'b0001 << a;
            2'b01:   return a[1] ? 4'b1100 : 4'b0011;
            2'b10:   return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] d);
        case (f3[1:0])
            2'b00:   return {4{d[7:0]}};
            2'b01:   return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    // Address bits above the RAM size wrap away.
    assign unused_addr_s = ^addr[31:IDX_W+2];

    assign widx_s        = addr_q[IDX_W+1:2];
    assign lane_s        = addr_q[1:0];
    assign be_s          = byte_en(funct3_q, lane_s);
    assign store_lanes_s = store_lanes(funct3_q, wdata_q);
    assign load_data_s   = load_ext(funct3_q, lane_s, mem_q[widx_s]);

    // Legal encodings; BU/HU exist only as loads.
    always_comb begin
        legal_s = 1'b0;
        case (funct3_q)
            3'b000, 3'b001, 3'b010: legal_s = 1'b1;
            3'b100, 3'b101:         legal_s = ~we_q;
            default:                legal_s = 1'b0;
        endcase
    end

`ifdef MISALIGN_TRAP_EN
    logic mis_q;

    // Misalignment is only meaningful for a legal access.
    always_comb begin
        mis_s = 1'b0;
        if (legal_s) begin
            case (funct3_q)
                3'b001, 3'b101: mis_s = lane_s[0];
                3'b010:         mis_s = |lane_s;
                default:        mis_s = 1'b0;
            endcase
        end else begin
            mis_s = 1'b0;
        end
    end

    // Misaligned flag is visible only in RESP.
    always_ff @(posedge clk) begin
        if (rst) begin
            mis_q <= 1'b0;
        end else begin
            mis_q <= (state_q == ACCESS) & mis_s;
        end
    end

    assign misaligned = mis_q;
`else
    assign mis_s      = 1'b0;
    assign misaligned = 1'b0;
`endif

    // Reset in ACCESS must suppress the pending write.
    assign wr_en_s = (state_q == ACCESS) & ~rst & we_q & legal_s & ~mis_s;

    // Next-state, request latching and response data.
    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        funct3_d = funct3_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        done_d   = 1'b0;
        busy_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    state_d  = ACCESS;
                    we_d     = we;
                    funct3_d = funct3;
                    addr_d   = addr[IDX_W+1:0];
                    wdata_d  = wdata;
                    busy_d   = 1'b1;
                end else begin
                    state_d  = IDLE;
                end
            end
            ACCESS: begin
                state_d = RESP;
                busy_d  = 1'b1;
                done_d  = 1'b1;
                rdata_d = (we_q | ~legal_s | mis_s) ? 32'd0 : load_data_s;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            we_q     <= 1'b0;
            funct3_q <= 3'd0;
            addr_q   <= '0;
            wdata_q  <= 32'd0;
            rdata_q  <= 32'd0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    // Byte-lane RAM write; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            for (int i = 0; i < 4; i++) begin
                if (be_s[i]) begin
                    mem_q[widx_s][8*i +: 8] <= store_lanes_s[8*i +: 8];
                end
            end
        end
    end

    assign rdata = rdata_q;
    assign done  = done_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_data_mem_unit.sv
// Self-checking bench for data_mem_unit: directed vector table, reset/handshake corner sequences,
// and random accesses checked against a byte-array memory model.
module tb_data_mem_unit;

    localparam int DEPTH = 256;
    localparam int BYTES = DEPTH * 4;

    logic        clk, rst, req, we;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata, rdata;
    logic        done, busy, misaligned;

    int n_eval = 0;
    int n_fail = 0;

    logic [7:0] ref_mem [BYTES];

    typedef struct {
        bit          we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        bit          exp_mis;
        string       name;
    } vec_t;

    vec_t vecs[$];

    data_mem_unit #(.DEPTH_WORDS(DEPTH)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .funct3(funct3), .addr(addr),
        .wdata(wdata), .rdata(rdata), .done(done), .busy(busy), .misaligned(misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_eval++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: RAM as a flat byte array, little-endian, address modulo the RAM size.
    task automatic model(input bit w, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] d, output logic [31:0] rd, output bit mis);
        int base, size;
        bit legal;
        logic [31:0] val;
        rd = 32'd0;
        mis = 1'b0;
        legal = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2) || ((f3 == 3'd4 || f3 == 3'd5) && !w);
        if (!legal) return;
        size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        base = int'(a % 32'(BYTES));
        if (base % size != 0) begin
`ifdef MISALIGN_TRAP_EN
            mis = 1'b1;
            return;
`else
            base = base - (base % size);
`endif
        end
        if (w) begin
            for (int i = 0; i < size; i++) ref_mem[base + i] = d[8*i +: 8];
        end else begin
            val = 32'd0;
            for (int i = 0; i < size; i++) val[8*i +: 8] = ref_mem[base + i];
            if (!f3[2] && val[8*size - 1]) begin
                for (int i = size; i < 4; i++) val[8*i +: 8] = 8'hFF;
            end
            rd = val;
        end
    endtask

    // Called #1 after a rising edge with the DUT in IDLE; returns on the same phase, back in IDLE.
    task automatic run_access(input bit w, input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] d, output logic [31:0] got_rd,
                              output logic got_mis, output logic [5:0] hs);
        req = 1'b1; we = w; funct3 = f3; addr = a; wdata = d;
        @(posedge clk); #1;
        req = 1'b0;
        hs[5:4] = {busy, done};
        @(posedge clk); #1;
        hs[3:2] = {busy, done};
        got_rd  = rdata;
        got_mis = misaligned;
        @(posedge clk); #1;
        hs[1:0] = {busy, done};
    endtask

    task automatic access_vs_model(input string nm, input bit w, input logic [2:0] f3,
                                   input logic [31:0] a, input logic [31:0] d);
        logic [31:0] got_rd, exp_rd;
        logic        got_mis;
        bit          exp_mis;
        logic [5:0]  hs;
        run_access(w, f3, a, d, got_rd, got_mis, hs);
        model(w, f3, a, d, exp_rd, exp_mis);
        check({nm, "_handshake"}, 64'(hs), 64'(6'b10_11_00));
        check({nm, "_rdata"}, 64'(got_rd), 64'(exp_rd));
        check({nm, "_mis"}, 64'(got_mis), 64'(exp_mis));
    endtask

    task automatic add_vec(input bit w, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] d, input logic [31:0] er, input bit em,
                           input string nm);
        vec_t v;
        v.we = w; v.f3 = f3; v.addr = a; v.wdata = d;
        v.exp_rd = er; v.exp_mis = em; v.name = nm;
        vecs.push_back(v);
    endtask

    initial begin
        logic [31:0] got_rd, mrd;
        logic        got_mis;
        bit          mmis;
        logic [5:0]  hs;
        int          dones;
        logic [2:0]  rf3;
        bit          rwe;

        // Directed vectors with constant expectations.
        add_vec(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, "sw_10");
        add_vec(1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, "lw_10");
        add_vec(1'b1, 3'b010, 32'h10, 32'h11223344, 32'h0, 1'b0, "sw_10b");
        add_vec(1'b1, 3'b000, 32'h11, 32'h000000AA, 32'h0, 1'b0, "sb_11");
        add_vec(1'b0, 3'b010, 32'h10, 32'h0, 32'h1122AA44, 1'b0, "lw_after_sb");
        add_vec(1'b0, 3'b000, 32'h11, 32'h0, 32'hFFFFFFAA, 1'b0, "lb_11");
        add_vec(1'b0, 3'b100, 32'h11, 32'h0, 32'h000000AA, 1'b0, "lbu_11");
        add_vec(1'b1, 3'b010, 32'h20, 32'h0, 32'h0, 1'b0, "sw_20_zero");
        add_vec(1'b1, 3'b001, 32'h22, 32'h12348001, 32'h0, 1'b0, "sh_22");
        add_vec(1'b0, 3'b001, 32'h22, 32'h0, 32'hFFFF8001, 1'b0, "lh_22");
        add_vec(1'b0, 3'b101, 32'h22, 32'h0, 32'h00008001, 1'b0, "lhu_22");
        add_vec(1'b0, 3'b010, 32'h20, 32'h0, 32'h80010000, 1'b0, "lw_20");
        add_vec(1'b1, 3'b010, 32'(BYTES + 4), 32'h5A5A5A5A, 32'h0, 1'b0, "sw_wrap");
        add_vec(1'b0, 3'b010, 32'h4, 32'h0, 32'h5A5A5A5A, 1'b0, "lw_4_wrap");
        add_vec(1'b1, 3'b010, 32'h30, 32'h12345678, 32'h0, 1'b0, "sw_30");
`ifdef MISALIGN_TRAP_EN
        add_vec(1'b0, 3'b010, 32'h31, 32'h0, 32'h0, 1'b1, "lw_31_misaligned");
        add_vec(1'b1, 3'b001, 32'h33, 32'h0000BEEF, 32'h0, 1'b1, "sh_33_misaligned");
        add_vec(1'b0, 3'b010, 32'h30, 32'h0, 32'h12345678, 1'b0, "lw_30_after_sh33");
`else
        add_vec(1'b0, 3'b010, 32'h31, 32'h0, 32'h12345678, 1'b0, "lw_31_truncated");
        add_vec(1'b1, 3'b001, 32'h33, 32'h0000BEEF, 32'h0, 1'b0, "sh_33_truncated");
        add_vec(1'b0, 3'b010, 32'h30, 32'h0, 32'hBEEF5678, 1'b0, "lw_30_after_sh33");
`endif
        add_vec(1'b1, 3'b010, 32'h30, 32'h12345678, 32'h0, 1'b0, "sw_30_restore");
        add_vec(1'b0, 3'b011, 32'h30, 32'h0, 32'h0, 1'b0, "illegal_f3_011");
        add_vec(1'b1, 3'b100, 32'h30, 32'hFFFFFFFF, 32'h0, 1'b0, "illegal_store_bu");
        add_vec(1'b1, 3'b111, 32'h30, 32'hFFFFFFFF, 32'h0, 1'b0, "illegal_store_111");
        add_vec(1'b0, 3'b010, 32'h30, 32'h0, 32'h12345678, 1'b0, "lw_30_no_illegal_write");

        rst = 1'b1; req = 1'b0; we = 1'b0; funct3 = 3'd0; addr = 32'd0; wdata = 32'd0;
        @(posedge clk); @(posedge clk); #1;
        check("reset_outputs", {rdata, done, busy, misaligned}, 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Give every word a known value so later loads are fully predictable.
        for (int i = 0; i < DEPTH; i++) begin
            wdata = $urandom;
            run_access(1'b1, 3'b010, 32'(i * 4), wdata, got_rd, got_mis, hs);
            model(1'b1, 3'b010, 32'(i * 4), wdata, mrd, mmis);
        end
        check("fill_last_handshake", 64'(hs), 64'(6'b10_11_00));

        foreach (vecs[k]) begin
            run_access(vecs[k].we, vecs[k].f3, vecs[k].addr, vecs[k].wdata, got_rd, got_mis, hs);
            model(vecs[k].we, vecs[k].f3, vecs[k].addr, vecs[k].wdata, mrd, mmis);
            check({vecs[k].name, "_handshake"}, 64'(hs), 64'(6'b10_11_00));
            check({vecs[k].name, "_rdata"}, 64'(got_rd), 64'(vecs[k].exp_rd));
            check({vecs[k].name, "_mis"}, 64'(got_mis), 64'(vecs[k].exp_mis));
        end

        // rdata holds its RESP value while idle.
        run_access(1'b0, 3'b010, 32'h30, 32'h0, got_rd, got_mis, hs);
        repeat (3) @(posedge clk);
        #1;
        check("rdata_hold", 64'(rdata), 64'h12345678);

        // Reset during ACCESS of a store: no write, no done, outputs cleared.
        req = 1'b1; we = 1'b1; funct3 = 3'b010; addr = 32'h30; wdata = 32'h0;
        @(posedge clk); #1;
        req = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_access_outputs", {rdata, done, busy, misaligned}, 64'd0);
        dones = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (done) dones++;
        end
        check("rst_access_no_done", 64'(dones), 64'd0);
        run_access(1'b0, 3'b010, 32'h30, 32'h0, got_rd, got_mis, hs);
        check("rst_access_no_write", 64'(got_rd), 64'h12345678);

        // Reset during RESP clears done, busy and rdata on the next edge.
        req = 1'b1; we = 1'b0; funct3 = 3'b010; addr = 32'h30;
        @(posedge clk); #1;
        req = 1'b0;
        @(posedge clk); #1;
        check("resp_before_rst", {rdata, done, busy}, {32'h12345678, 1'b1, 1'b1});
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_resp_outputs", {rdata, done, busy, misaligned}, 64'd0);

        // req held through ACCESS with a different address must not start a second access.
        req = 1'b1; we = 1'b1; funct3 = 3'b010; addr = 32'h8; wdata = 32'hCAFEF00D;
        @(posedge clk); #1;
        addr = 32'h40; wdata = 32'h0BADBEEF;
        dones = 0;
        @(posedge clk); #1;
        req = 1'b0;
        if (done) dones++;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (done) dones++;
        end
        check("busy_req_ignored_done_count", 64'(dones), 64'd1);
        model(1'b1, 3'b010, 32'h8, 32'hCAFEF00D, mrd, mmis);
        access_vs_model("lw_8_after_busy_req", 1'b0, 3'b010, 32'h8, 32'h0);
        access_vs_model("lw_40_untouched", 1'b0, 3'b010, 32'h40, 32'h0);

        // Random traffic against the byte-array model.
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(9) == 0) rf3 = 3'($urandom);
            else begin
                case ($urandom_range(4))
                    0: rf3 = 3'b000;
                    1: rf3 = 3'b001;
                    2: rf3 = 3'b010;
                    3: rf3 = 3'b100;
                    default: rf3 = 3'b101;
                endcase
            end
            rwe = 1'($urandom_range(1));
            access_vs_model("rand", rwe, rf3, $urandom, $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_eval, n_fail);
        $finish;
    end

endmodule
